slice_alu_sequencer: RTL
========================

SLICE_ALU_SEQUENCER -- requirements
Module: slice_alu_sequencer

Interface
REQ-001 Parameter SLICE_W, default 4: width of one ALU slice in bits.
REQ-002 Parameter N_SLICES, default 4: number of slices per operand; operand width W = SLICE_W*N_SLICES.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101-111 reserved.
REQ-007 a, b  input  W  operands; sampled on the accepting edge only.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse, result and cout valid.
REQ-010 result  output  W  registered result, held until the next done.
REQ-011 cout  output  1  final carry (ADD: carry out; SUB: 1 = no borrow; logic/reserved: 0).

Function
REQ-012 The block SHALL compute a W-bit operation serially through one SLICE_W-bit slice, LSB slice first, one slice per clock.
REQ-013 FSM states: IDLE, RUN, DONE; IDLE->RUN on start=1, RUN->DONE after slice N_SLICES-1, DONE->IDLE unconditionally next edge.
REQ-014 Accept edge: latch a, b, op; clear slice index to 0; load carry register with 1 for SUB, else 0.
REQ-015 Each RUN edge: write slice result into result-shadow bits [idx*SLICE_W +: SLICE_W], update carry register, increment idx.
REQ-016 SUB SHALL use b inverted and carry-in 1; logic ops SHALL drive slice mode M=1 so carries are ignored.
REQ-017 Reserved opcodes SHALL produce result 0 and cout 0 with normal latency.
REQ-018 done SHALL assert exactly N_SLICES+1 edges after the accept edge (DONE state), for one cycle; result and cout update on that same edge.
REQ-019 busy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-020 start while busy=1 SHALL be ignored, with no queuing; start in the DONE cycle is also ignored.
REQ-021 start held high continuously SHALL launch back-to-back operations, each accepted in IDLE.
REQ-022 Operand changes after the accept edge SHALL NOT affect the in-flight result.

Reset
REQ-023 rst=1 SHALL immediately force IDLE, busy=0, done=0, result=0, cout=0, idx=0, carry register=0.
REQ-024 Reset mid-operation SHALL abandon the operation; no done pulse SHALL follow release.
REQ-025 The first accept is possible on the first rising edge after rst deasserts.

Configuration
REQ-026 Macro SLICE_SEQ_FLAGS_EN: when defined, outputs zero, neg, ovf (1 bit each) SHALL be added, registered with done.
REQ-027 zero = (result==0); neg = result[W-1]; ovf = signed overflow for ADD/SUB, else 0.
REQ-028 When the macro is not defined, those ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package slice_alu_pkg SHALL hold the opcode constants, FSM state encoding, and default SLICE_W/N_SLICES.
REQ-030 Sub-module alu_slice SHALL implement one SLICE_W-bit slice (inputs x, y, cin, M, op; outputs f, cout) and be instantiated once.

Verification
REQ-031 ADD a=0x1234 b=0x0FFF start 1 cycle -> done after 5 edges, result=0x2233, cout=0, busy high 5 cycles.
REQ-032 SUB a=0x0000 b=0x0001 -> result=0xFFFF, cout=0; SUB a=0x0005 b=0x0003 -> 0x0002, cout=1.
REQ-033 AND/OR/XOR a=0xF0F0 b=0xFF00 -> 0xF000 / 0xFFF0 / 0x0FF0, cout=0 each.
REQ-034 ADD 0x0001+0x0001 started, then start with op=XOR and new operands 2 cycles later -> single done, result=0x0002.
REQ-035 rst pulse on the 3rd RUN edge -> outputs 0 immediately, no done for 10 cycles; next ADD 0xFFFF+0x0001 -> 0x0000, cout=1.
REQ-036 With SLICE_SEQ_FLAGS_EN: ADD 0x7FFF+0x0001 -> result 0x8000, ovf=1, neg=1, zero=0; SUB 0x1234-0x1234 -> zero=1, ovf=0.

Source files
------------

// File: rtl/slice_alu_pkg.sv
// Shared constants for the slice ALU sequencer: opcodes, FSM states, default geometry.
package slice_alu_pkg;

  localparam int SLICE_W_DEF  = 4;
  localparam int N_SLICES_DEF = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Arithmetic ops propagate carries; everything else runs the slice in logic mode.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/slice_alu_sequencer_alu_slice.sv
// One SLICE_W-bit ALU slice: add/sub with carry chain, or bitwise logic when M=1.
module alu_slice
  import slice_alu_pkg::*;
#(
  parameter int SLICE_W = SLICE_W_DEF
) (
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               cin,
  input  logic               M,
  input  logic [2:0]         op,
  output logic [SLICE_W-1:0] f,
  output logic               cout
);

  logic [SLICE_W-1:0] y_eff;
  logic [SLICE_W:0]   sum;

  always_comb begin
    y_eff = (op == OP_SUB) ? ~y : y;
    sum   = {1'b0, x} + {1'b0, y_eff} + {{SLICE_W{1'b0}}, cin};
    f     = sum[SLICE_W-1:0];
    cout  = sum[SLICE_W];
    if (M) begin
      cout = 1'b0;
      unique case (op)
        OP_AND:  f = x & y;
        OP_OR:   f = x | y;
        OP_XOR:  f = x ^ y;
        default: f = '0;
      endcase
    end
  end

endmodule

// File: rtl/slice_alu_sequencer.sv
// Serial W-bit ALU: one slice per clock, LSB first, through a single alu_slice.
// Optional zero/neg/ovf flag outputs are enabled by defining SLICE_SEQ_FLAGS_EN.
module slice_alu_sequencer
  import slice_alu_pkg::*;
#(
  parameter int SLICE_W  = SLICE_W_DEF,
  parameter int N_SLICES = N_SLICES_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [2:0]                    op,
  input  logic [SLICE_W*N_SLICES-1:0]   a,
  input  logic [SLICE_W*N_SLICES-1:0]   b,
  output logic                          busy,
  output logic                          done,
  output logic [SLICE_W*N_SLICES-1:0]   result,
  output logic                          cout
`ifdef SLICE_SEQ_FLAGS_EN
  ,
  output logic                          zero,
  output logic                          neg,
  output logic                          ovf
`endif
);

  localparam int W     = SLICE_W * N_SLICES;
  localparam int IDX_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLICES - 1);

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       shadow_q, shadow_d;
  logic [W-1:0]       result_q, result_d;
  logic               cout_q, cout_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
`ifdef SLICE_SEQ_FLAGS_EN
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
`endif

  logic [SLICE_W-1:0] a_sl [N_SLICES];
  logic [SLICE_W-1:0] b_sl [N_SLICES];
  logic [W-1:0]       shadow_wr;
  logic [SLICE_W-1:0] slice_f;
  logic               slice_cout;

  // shadow_wr is the shadow with the current slice merged in; it feeds both the
  // shadow register and, on the last slice, the result register.
  genvar gi;
  generate
    for (gi = 0; gi < N_SLICES; gi++) begin : g_slice
      assign a_sl[gi] = a_q[gi*SLICE_W +: SLICE_W];
      assign b_sl[gi] = b_q[gi*SLICE_W +: SLICE_W];
      assign shadow_wr[gi*SLICE_W +: SLICE_W] =
        (idx_q == IDX_W'(gi)) ? slice_f : shadow_q[gi*SLICE_W +: SLICE_W];
    end
  endgenerate

  alu_slice #(
    .SLICE_W (SLICE_W)
  ) u_slice (
    .x    (a_sl[idx_q]),
    .y    (b_sl[idx_q]),
    .cin  (carry_q),
    .M    (!is_arith(op_q)),
    .op   (op_q),
    .f    (slice_f),
    .cout (slice_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    shadow_d = shadow_q;
    result_d = result_q;
    cout_d   = cout_q;
    done_d   = 1'b0;
`ifdef SLICE_SEQ_FLAGS_EN
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          idx_d   = '0;
          carry_d = (op == OP_SUB);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        shadow_d = shadow_wr;
        carry_d  = slice_cout;
        idx_d    = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d  = ST_DONE;
          result_d = shadow_wr;
          cout_d   = slice_cout;
          done_d   = 1'b1;
`ifdef SLICE_SEQ_FLAGS_EN
          zero_d = (shadow_wr == '0);
          neg_d  = shadow_wr[W-1];
          unique case (op_q)
            OP_ADD:  ovf_d = (a_q[W-1] == b_q[W-1]) && (shadow_wr[W-1] != a_q[W-1]);
            OP_SUB:  ovf_d = (a_q[W-1] != b_q[W-1]) && (shadow_wr[W-1] != a_q[W-1]);
            default: ovf_d = 1'b0;
          endcase
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      shadow_q <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef SLICE_SEQ_FLAGS_EN
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef SLICE_SEQ_FLAGS_EN
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
`ifdef SLICE_SEQ_FLAGS_EN
  assign zero   = zero_q;
  assign neg    = neg_q;
  assign ovf    = ovf_q;
`endif

endmodule
